// File: rtl/cci_mpf_shim_tx_issue_sched.sv
// Issue scheduler: drains the c0 read and c1 write FIFOs into one registered request
// stream. It arbitrates round-robin with a bounded c1 burst and uses almost-full slack credits.
module cci_mpf_shim_tx_issue_sched #(
  parameter int C0_BITS      = 64,
  parameter int C1_BITS      = 600,
  parameter int SLACK        = 4,
  parameter int MAX_C1_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               c0_not_empty,
  input  logic [C0_BITS-1:0] c0_first,
  output logic               deq_c0,
  input  logic               c1_not_empty,
  input  logic [C1_BITS-1:0] c1_first,
  output logic               deq_c1,
  input  logic               dn_almost_full,
  output logic               out_valid,
  output logic               out_is_c1,
  output logic [C0_BITS-1:0] out_c0,
  output logic [C1_BITS-1:0] out_c1,
  output logic [2:0]         credits
);
  localparam logic [2:0] SLACK_C = 3'(SLACK);
  localparam logic [3:0] MAX_B   = 4'(MAX_C1_BURST);

  typedef enum logic [1:0] {RUN, THROTTLE, BLOCKED} state_e;

  state_e             state_q, state_d;
  logic [2:0]         credits_q, credits_d;
  logic               rr_last_q, rr_last_d;   // 1 = c1 granted last
  logic [3:0]         burst_q, burst_d;
  logic               out_valid_q, out_is_c1_q;
  logic [C0_BITS-1:0] out_c0_q;
  logic [C1_BITS-1:0] out_c1_q;
  logic               issue_en, gnt0, gnt1, gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // The state follows the credit count that will exist after this edge.
  always_comb begin
    state_d = state_q;
    if (!dn_almost_full)      state_d = RUN;
    else if (credits_d != '0) state_d = THROTTLE;
    else                      state_d = BLOCKED;
  end

  always_comb begin
    issue_en = (!dn_almost_full || credits_q != '0) &&
               !(state_q == BLOCKED && dn_almost_full);
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (issue_en && !reset) begin
      if (c0_not_empty && c1_not_empty) begin
        if (burst_q == MAX_B || rr_last_q) gnt0 = 1'b1;
        else                               gnt1 = 1'b1;
      end else begin
        gnt0 = c0_not_empty;
        gnt1 = c1_not_empty;
      end
    end
    gnt = gnt0 | gnt1;
  end

  always_comb begin
    credits_d = credits_q;
    if (!dn_almost_full)              credits_d = SLACK_C;
    else if (gnt && credits_q != '0)  credits_d = credits_q - 3'd1;

    rr_last_d = gnt ? gnt1 : rr_last_q;

    burst_d = burst_q;
    if (gnt0)      burst_d = '0;
    else if (gnt1) burst_d = (burst_q == MAX_B) ? MAX_B : burst_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q <= SLACK_C;
      rr_last_q <= 1'b1;
      burst_q   <= '0;
    end else begin
      credits_q <= credits_d;
      rr_last_q <= rr_last_d;
      burst_q   <= burst_d;
    end
  end

  // Only the granted channel's payload register loads; the other holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_is_c1_q <= 1'b0;
      out_c0_q    <= '0;
      out_c1_q    <= '0;
    end else begin
      out_valid_q <= gnt;
      if (gnt)  out_is_c1_q <= gnt1;
      if (gnt0) out_c0_q    <= c0_first;
      if (gnt1) out_c1_q    <= c1_first;
    end
  end

  assign deq_c0    = gnt0;
  assign deq_c1    = gnt1;
  assign out_valid = out_valid_q;
  assign out_is_c1 = out_is_c1_q;
  assign out_c0    = out_c0_q;
  assign out_c1    = out_c1_q;
  assign credits   = credits_q;
endmodule

// File: tb/tb_cci_mpf_shim_tx_issue_sched.sv
// Bench for the tx issue scheduler: a cycle model of grants, credits and output regs,
// checked every negedge, plus literal expectations at key points of each scenario.
module tb_cci_mpf_shim_tx_issue_sched;
  localparam int C0_BITS = 64, C1_BITS = 600, SLACK = 4, MAXB = 4;

  logic clk = 0, reset = 1;
  logic v0 = 0, v1 = 0, af = 0;
  logic [31:0] cnt0 = 0, cnt1 = 0;
  logic [C0_BITS-1:0] c0_first;
  logic [C1_BITS-1:0] c1_first;
  logic deq_c0, deq_c1, out_valid, out_is_c1;
  logic [C0_BITS-1:0] out_c0;
  logic [C1_BITS-1:0] out_c1;
  logic [2:0] credits;

  int tests = 0, fails = 0;
  int n0 = 0, n1 = 0;
  bit pop0 = 0, pop1 = 0;

  // Model state
  int m_cred, m_burst;
  bit m_rr, m_ov, m_isc1;
  logic [C0_BITS-1:0] m_c0;
  logic [C1_BITS-1:0] m_c1;

  assign c0_first = {32'hC0DE_0000, cnt0};
  assign c1_first = {cnt1, {(C1_BITS-64){1'b1}}, cnt1};

  cci_mpf_shim_tx_issue_sched #(.C0_BITS(C0_BITS), .C1_BITS(C1_BITS),
    .SLACK(SLACK), .MAX_C1_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .c0_not_empty(v0), .c0_first(c0_first), .deq_c0(deq_c0),
    .c1_not_empty(v1), .c1_first(c1_first), .deq_c1(deq_c1),
    .dn_almost_full(af),
    .out_valid(out_valid), .out_is_c1(out_is_c1),
    .out_c0(out_c0), .out_c1(out_c1), .credits(credits));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [C1_BITS-1:0] act,
                     input logic [C1_BITS-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs reflect the previous edge, then the grant for this cycle.
  always @(negedge clk) begin
    bit g0, g1;
    g0 = 0; g1 = 0;
    if (reset) begin
      chk("rst_deq", {deq_c0, deq_c1}, 0);
      chk("rst_ov", out_valid, 0);
      chk("rst_cred", credits, SLACK);
      m_cred = SLACK; m_rr = 1; m_burst = 0;
      m_ov = 0; m_isc1 = 0; m_c0 = '0; m_c1 = '0;
    end else begin
      chk("ov", out_valid, m_ov);
      if (m_ov) chk("is_c1", out_is_c1, m_isc1);
      chk("out_c0", out_c0, m_c0);
      chk("out_c1", out_c1, m_c1);
      chk("cred", credits, m_cred);
      if (!af || m_cred > 0) begin
        if (v0 && v1) begin
          if (m_burst == MAXB) g0 = 1;
          else if (m_rr) g0 = 1;
          else g1 = 1;
        end else begin
          g0 = v0; g1 = v1;
        end
      end
      chk("deq", {deq_c0, deq_c1}, {g0, g1});
      m_ov = g0 | g1;
      if (g0) begin m_isc1 = 0; m_c0 = c0_first; m_rr = 0; m_burst = 0; n0++; end
      if (g1) begin
        m_isc1 = 1; m_c1 = c1_first; m_rr = 1; n1++;
        if (m_burst < MAXB) m_burst++;
      end
      if (!af) m_cred = SLACK;
      else if ((g0 | g1) && m_cred > 0) m_cred--;
    end
    pop0 = g0; pop1 = g1;
  end

  task automatic drive(input logic b0, b1, a, r, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (pop0) cnt0++;
      if (pop1) cnt1++;
      pop0 = 0; pop1 = 0;
      v0 = b0; v1 = b1; af = a; reset = r;
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    v0 = 1; v1 = 1;
    drive(1, 1, 0, 1, 3);
    settle();
    chk("lit_rst_deq", {deq_c0, deq_c1}, 2'b00);
    // First grant after reset goes to c0
    drive(1, 1, 0, 0, 1); settle();
    chk("lit_first_c0", {deq_c0, deq_c1}, 2'b10);
    chk("lit_first_cred", credits, 3'd4);
    n0 = 0; n1 = 0;
    drive(1, 1, 0, 0, 8); settle();
    chk("lit_alt_n0", n0, 4);
    chk("lit_alt_n1", n1, 4);

    // c1 alone, then idle (burst must survive), then contention
    n1 = 0;
    drive(0, 1, 0, 0, 6); settle();
    chk("lit_c1_only", n1, 6);
    drive(0, 0, 0, 0, 2);
    drive(1, 1, 0, 0, 1); settle();
    chk("lit_burst_c0", {deq_c0, deq_c1}, 2'b10);
    n0 = 0; n1 = 0;
    drive(1, 1, 0, 0, 4); settle();
    chk("lit_post_burst_n0", n0, 2);

    // Almost-full: exactly SLACK further grants
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 1, 0, 1); settle();
      chk("lit_af_cred", credits, (k < 4) ? 4 - k : 0);
      if (k >= 4) chk("lit_blocked_deq", {deq_c0, deq_c1}, 2'b00);
    end
    chk("lit_af_grants", n0 + n1, 4);
    drive(1, 1, 0, 0, 1); settle();
    chk("lit_resume_deq", deq_c0 | deq_c1, 1'b1);
    chk("lit_resume_cred0", credits, 3'd0);
    drive(1, 1, 0, 0, 1); settle();
    chk("lit_reload", credits, 3'd4);

    // Drain credits with one channel, then toggle almost-full
    drive(0, 1, 1, 0, 6);
    for (int k = 0; k < 16; k++) drive(1, 0, k[0], 0, 1);
    drive(0, 1, 1, 0, 3);
    for (int k = 0; k < 10; k++) drive(0, 1, ~k[0], 0, 1);

    // Mid-stream reset with both FIFOs non-empty
    drive(1, 1, 0, 0, 3);
    chk("lit_pre_rst_ov", out_valid, 1'b1);
    reset = 1; #1;
    chk("lit_async_ov", out_valid, 1'b0);
    drive(1, 1, 0, 1, 2); settle();
    chk("lit_rst_deq2", {deq_c0, deq_c1}, 2'b00);
    drive(1, 1, 0, 0, 1); settle();
    chk("lit_rst_first_c0", {deq_c0, deq_c1}, 2'b10);
    drive(1, 1, 0, 0, 1);
    chk("lit_rst_out", {out_valid, out_is_c1}, 2'b10);
    drive(0, 0, 0, 0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cci_mpf_shim_tx_issue_sched.md
Name: cci_mpf_shim_tx_issue_sched

Overview:
- Issue scheduler that drains the two buffered AFU request FIFOs (channel 0 read headers, channel 1 write requests) onto a single shared request pipeline toward the QLP.
- Generates the per-channel dequeue strobes, so the FIFOs remain latency insensitive.
- Arbitrates round-robin with a bounded write-burst length.
- Honours the downstream almost-full protocol with a slack-credit counter.

Parameters:
- C0_BITS, 64, width of a channel 0 request header.
- C1_BITS, 600, width of a full channel 1 request (header plus line data).
- SLACK, 4, requests still allowed after dn_almost_full rises (CCI almost-full threshold).
- MAX_C1_BURST, 4, maximum consecutive channel 1 grants while channel 0 is waiting (1..15).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- c0_not_empty  in  1  channel 0 FIFO head valid.
- c0_first  in  C0_BITS  channel 0 FIFO head.
- deq_c0  out  1  dequeue channel 0 head this cycle (combinational).
- c1_not_empty  in  1  channel 1 FIFO head valid.
- c1_first  in  C1_BITS  channel 1 FIFO head.
- deq_c1  out  1  dequeue channel 1 head this cycle (combinational).
- dn_almost_full  in  1  downstream almost-full.
- out_valid  out  1  registered request valid.
- out_is_c1  out  1  registered: 1 = write request, 0 = read.
- out_c0  out  C0_BITS  registered read header, meaningful when out_valid && !out_is_c1.
- out_c1  out  C1_BITS  registered write request, meaningful when out_valid && out_is_c1.
- credits  out  3  current slack credits (debug).

Behaviour:
- Reset (async assert, sync deassert usage):
  - out_valid = 0, out_is_c1 = 0, out_c0 = 0, out_c1 = 0.
  - credits = SLACK, rr_last = c1 (so channel 0 wins the first tie), c1_burst = 0, FSM = RUN.
  - deq_c0 and deq_c1 are forced 0 while reset is high.
  - Reset mid-operation discards any registered output; FIFO heads are untouched because no deq fires.
- can_issue = !dn_almost_full || credits != 0.
- Credits:
  - While dn_almost_full = 0, credits reloads to SLACK every cycle.
  - While dn_almost_full = 1, each grant decrements credits by 1; credits saturate at 0 and never underflow.
  - Reload takes priority over decrement in the same cycle.
- FSM, registered, evaluated each cycle:
  - RUN: taken when !dn_almost_full.
  - THROTTLE: taken when dn_almost_full && credits > 0.
  - BLOCKED: taken when dn_almost_full && credits == 0.
  - RUN -> THROTTLE on the almost-full rise. THROTTLE -> BLOCKED when the last credit is spent. Any state -> RUN when almost-full falls.
  - No grants are issued in BLOCKED.
- Arbitration (combinational), issued only when can_issue:
  - Only one channel valid: grant it.
  - Both valid and c1_burst == MAX_C1_BURST: grant c0.
  - Both valid otherwise: grant the channel not equal to rr_last.
- deq_c0 / deq_c1 equal the grant, at most one high per cycle. The head is consumed in the grant cycle.
- Latency: exactly 1 cycle from grant to output.
  - Next edge: out_valid = 1, out_is_c1 = granted channel, and the granted head is captured into out_c0 or out_c1. The other payload register holds its value.
  - No grant: out_valid = 0.
- rr_last updates to the granted channel on every grant.
- c1_burst:
  - A c1 grant increments it, saturating at MAX_C1_BURST.
  - A c0 grant clears it.
  - It is unchanged when there is no grant; an idle cycle does not reset it.
- Simultaneous almost-full rise and grant: the grant proceeds when credits > 0, and credits decrement the same edge.

Test Plan:
- Reset asserted mid-stream, both FIFOs non-empty -> deq_c0 = deq_c1 = 0 during reset, and out_valid = 0 asynchronously. After release, the first grant is c0, and out_valid appears 1 cycle later with out_is_c1 = 0.
- Both channels continuously valid, dn_almost_full = 0 for 8 cycles -> grants alternate c0, c1, c0, c1 ..., with 4 of each.
- Only c1 valid for 6 cycles, then c0 joins, MAX_C1_BURST = 4 -> c1 granted 6 times, then c0 granted next. If c1 keeps the contention going, c0 is granted within 1 cycle.
- dn_almost_full rises with both channels valid, SLACK = 4 -> exactly 4 further grants; credits goes 4, 3, 2, 1, 0; FSM reaches BLOCKED; deq stays 0 until almost-full falls.
- dn_almost_full falls in BLOCKED -> credits = 4 on the next edge, and a grant resumes in the same cycle the flag is low.
- Almost-full toggles every cycle with a single channel valid -> credits never underflow, and no grant ever occurs while dn_almost_full = 1 && credits = 0.
